// File: rtl/mdio_txn_scheduler_pkg.sv
// mdio_pkg: Clause-22 frame constants, field positions, FSM state codes and frame builder.
package mdio_pkg;
    localparam int FRAME_W = 32;
    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] TA = 2'b10;
    localparam int ST_POS = 30;
    localparam int OP_POS = 28;
    localparam int PHY_POS = 23;
    localparam int REG_POS = 18;
    localparam int TA_POS = 16;
    localparam int DATA_POS = 0;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic wr,
        input logic [4:0] phyad,
        input logic [4:0] regad,
        input logic [15:0] wdata
    );
        logic [FRAME_W-1:0] f;
        f[ST_POS +: 2] = ST_C22;
        f[OP_POS +: 2] = wr ? OP_WR : OP_RD;
        f[PHY_POS +: 5] = phyad;
        f[REG_POS +: 5] = regad;
        f[TA_POS +: 2] = TA;
        f[DATA_POS +: 16] = wr ? wdata : 16'h0000;
        return f;
    endfunction
endpackage

// File: rtl/mdio_txn_scheduler_if.sv
// mdio_txn_scheduler_if: requester and MDIO-master signals; slave = scheduler side.
interface mdio_txn_scheduler_if
    import mdio_pkg::*;
#(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_write;
    logic [5*NUM_REQ-1:0] req_phyad;
    logic [5*NUM_REQ-1:0] req_regad;
    logic [16*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [15:0] rsp_rdata;
    logic rsp_err;
    logic busy;
    logic mdio_start;
    logic [FRAME_W-1:0] t_data;
    logic mst_done;
    logic [15:0] mst_rd_data;

    modport master (
        output req_valid, req_write, req_phyad, req_regad, req_wdata, mst_done, mst_rd_data,
        input req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdio_start, t_data
    );
    modport slave (
        input req_valid, req_write, req_phyad, req_regad, req_wdata, mst_done, mst_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdio_start, t_data
    );
endinterface

// File: rtl/mdio_txn_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1 with wrap.
module rr_arbiter #(parameter int N = 4) (
    input logic [N-1:0] req,
    input logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0] grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);
    logic found;

    always_comb begin
        found = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last_grant) + k) % N]) begin
                found = 1'b1;
                grant_idx = IW'((int'(last_grant) + k) % N);
            end
        end
        grant = found ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end
endmodule

// File: rtl/mdio_txn_scheduler.sv
// mdio_txn_scheduler: round-robin sharing of one MDIO master among NUM_REQ requesters.
// Optional WAIT timeout abort enabled by defining MDIO_TIMEOUT_EN.
module mdio_txn_scheduler
    import mdio_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic clk,
    input logic reset,
    mdio_txn_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [1:0] state;
    logic [IW-1:0] last_grant, g_q, g_idx;
    logic [NUM_REQ-1:0] grant;
    logic wr_q;
    logic [FRAME_W-1:0] frame_q;
    logic [15:0] rdata_q;
    logic timed_out;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req(bus.req_valid),
        .last_grant(last_grant),
        .grant(grant),
        .grant_idx(g_idx)
    );

`ifdef MDIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] cnt;
    logic err_q;
    // err_q tracks "no done in the last WAIT cycle", so it is valid once RESP is entered
    always_ff @(posedge clk) begin
        cnt <= (!reset || state != WAIT) ? '0 : cnt + 1'b1;
        err_q <= reset && state == WAIT && !bus.mst_done;
    end
    assign timed_out = state == WAIT && cnt == CW'(TIMEOUT_CYC - 1);
    assign bus.rsp_err = state == RESP && err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timed_out = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            g_q <= '0;
            wr_q <= 1'b0;
            frame_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (|bus.req_valid) begin
                    state <= ISSUE;
                    g_q <= g_idx;
                    wr_q <= bus.req_write[g_idx];
                    frame_q <= build_frame(bus.req_write[g_idx], bus.req_phyad[5*int'(g_idx) +: 5],
                                           bus.req_regad[5*int'(g_idx) +: 5], bus.req_wdata[16*int'(g_idx) +: 16]);
                end
                ISSUE: state <= WAIT;
                WAIT: if (bus.mst_done || timed_out) begin
                    state <= RESP;
                    rdata_q <= !bus.mst_done ? 16'hFFFF : wr_q ? 16'h0000 : bus.mst_rd_data;
                end
                default: begin
                    state <= IDLE;
                    last_grant <= g_q;
                end
            endcase
        end
    end

    assign bus.req_ready = (reset && state == IDLE) ? grant : '0;
    assign bus.mdio_start = state == ISSUE;
    assign bus.busy = state != IDLE;
    assign bus.t_data = (state == ISSUE || state == WAIT) ? frame_q : '0;
    assign bus.rsp_valid = state == RESP ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << g_q) : '0;
    assign bus.rsp_rdata = state == RESP ? rdata_q : '0;
endmodule

// File: tb/tb_mdio_txn_scheduler.sv
// tb_mdio_txn_scheduler: directed self-checking bench for mdio_txn_scheduler.
module tb_mdio_txn_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] rr_frame [4];
    logic [3:0] rr_wr;

    mdio_txn_scheduler_if #(.NUM_REQ(4)) bus ();

    mdio_txn_scheduler #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd);
        bus.req_write[idx] = wr;
        bus.req_phyad[idx*5 +: 5] = phy;
        bus.req_regad[idx*5 +: 5] = rg;
        bus.req_wdata[idx*16 +: 16] = wd;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // entered at posedge+1 of the cycle in which the grant is expected
    task automatic run_txn(input string tag, input int idx, input logic [31:0] frame, input logic [15:0] rd,
                           input logic [15:0] exp_rd, input bit drop, input bit spur);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(1) << idx);
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".idle_rsp"}, 32'(bus.rsp_valid), 32'd0);
        nxt();
        if (drop) bus.req_valid[idx] = 1'b0;
        bus.mst_done = spur;
        @(negedge clk);
        chk({tag, ".start"}, 32'(bus.mdio_start), 32'd1);
        chk({tag, ".frame_issue"}, bus.t_data, frame);
        chk({tag, ".ready_pulse"}, 32'(bus.req_ready), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        nxt();
        bus.mst_done = 1'b0;
        @(negedge clk);
        chk({tag, ".start_once"}, 32'(bus.mdio_start), 32'd0);
        chk({tag, ".frame_wait"}, bus.t_data, frame);
        chk({tag, ".wait_rsp"}, 32'(bus.rsp_valid), 32'd0);
        nxt();
        bus.mst_done = 1'b1;
        bus.mst_rd_data = rd;
        @(negedge clk);
        chk({tag, ".wait2_rsp"}, 32'(bus.rsp_valid), 32'd0);
        nxt();
        bus.mst_done = 1'b0;
        bus.mst_rd_data = 16'h0000;
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << idx);
        chk({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, ".frame_clr"}, bus.t_data, 32'd0);
        nxt();
    endtask

    initial begin
        rr_frame[0] = 32'h608A_0000;
        rr_frame[1] = 32'h510E_1234;
        rr_frame[2] = 32'h627E_0000;
        rr_frame[3] = 32'h5FFE_FFFF;
        rr_wr = 4'b1010;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_phyad = '0;
        bus.req_regad = '0;
        bus.req_wdata = '0;
        bus.mst_done = 1'b0;
        bus.mst_rd_data = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst.err", 32'(bus.rsp_err), 32'd0);
        chk("rst.start", 32'(bus.mdio_start), 32'd0);
        chk("rst.tdata", bus.t_data, 32'd0);
        nxt();
        reset = 1'b1;

        set_req(1, 1'b0, 5'h03, 5'h01, 16'hDEAD);
        bus.req_valid = 4'b0010;
        run_txn("read", 1, 32'h6186_0000, 16'h796D, 16'h796D, 1'b1, 1'b0);

        set_req(2, 1'b1, 5'h1F, 5'h00, 16'h8000);
        bus.req_valid = 4'b0100;
        run_txn("write", 2, 32'h5F82_8000, 16'h1234, 16'h0000, 1'b1, 1'b0);

        bus.mst_done = 1'b1;
        @(negedge clk);
        chk("spur_idle.busy", 32'(bus.busy), 32'd0);
        chk("spur_idle.rsp", 32'(bus.rsp_valid), 32'd0);
        nxt();
        bus.mst_done = 1'b0;
        set_req(3, 1'b0, 5'h05, 5'h05, 16'h5555);
        bus.req_valid = 4'b1000;
        run_txn("spur_issue", 3, 32'h6296_0000, 16'h0F0F, 16'h0F0F, 1'b1, 1'b1);

        set_req(0, 1'b0, 5'h01, 5'h02, 16'h7777);
        set_req(1, 1'b1, 5'h02, 5'h03, 16'h1234);
        set_req(2, 1'b0, 5'h04, 5'h1F, 16'h9999);
        set_req(3, 1'b1, 5'h1F, 5'h1F, 16'hFFFF);
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 8; t++)
            run_txn($sformatf("rr%0d", t), t % 4, rr_frame[t % 4], 16'hBEE0 | 16'(t),
                    rr_wr[t % 4] ? 16'h0000 : (16'hBEE0 | 16'(t)), 1'b0, 1'b0);
        bus.req_valid = 4'b0001;
        run_txn("solo0", 0, rr_frame[0], 16'h4321, 16'h4321, 1'b1, 1'b0);

        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("rstw.ready", 32'(bus.req_ready), 32'd4);
        nxt();
        bus.req_valid = 4'b0000;
        nxt();
        nxt();
        reset = 1'b0;
        nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("rstw.busy", 32'(bus.busy), 32'd0);
        chk("rstw.rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rstw.tdata", bus.t_data, 32'd0);
        chk("rstw.start", 32'(bus.mdio_start), 32'd0);
        chk("rstw.rdata", 32'(bus.rsp_rdata), 32'd0);
        nxt();
        @(negedge clk);
        chk("rstw.no_rsp", 32'(bus.rsp_valid), 32'd0);
        nxt();
        bus.req_valid = 4'b1111;
        run_txn("post_rst", 0, rr_frame[0], 16'h0101, 16'h0101, 1'b1, 1'b0);
        bus.req_valid = 4'b0000;

`ifdef MDIO_TIMEOUT_EN
        nxt();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("to.ready", 32'(bus.req_ready), 32'd2);
        nxt();
        bus.req_valid = 4'b0000;
        nxt();
        repeat (15) nxt();
        @(negedge clk);
        chk("to.early", 32'(bus.rsp_valid), 32'd0);
        chk("to.busy", 32'(bus.busy), 32'd1);
        nxt();
        @(negedge clk);
        chk("to.rsp_valid", 32'(bus.rsp_valid), 32'd2);
        chk("to.err", 32'(bus.rsp_err), 32'd1);
        chk("to.rdata", 32'(bus.rsp_rdata), 32'h0000_FFFF);
        nxt();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
